// File: rtl/moving_avg_sched.sv
// moving_avg_sched: four-channel 4-tap moving average sharing a single
// accumulator. A round-robin arbiter picks one requesting channel per
// transaction. The new sample is pushed into that channel's history, the
// four taps are summed over four cycles, and the floor of sum/4 is presented.
//
// Ports
//   system1000      clock, rising edge
//   system1000_rst  asynchronous active-high reset
//   req_i[3:0]      per-channel sample request
//   data_i[31:0]    four signed 8-bit samples, channel k at [8k+7:8k]
//   flush_i         clear all histories (IDLE only, wins over req_i)
//   ack_o[3:0]      one-hot grant, high for one cycle after the grant edge
//   avg_o[7:0]      signed moving average, held between results
//   chan_o[1:0]     channel of avg_o
//   valid_o         one-cycle qualifier for avg_o/chan_o
//   busy_o          high while a transaction is in flight

// Per-channel 4-deep sample history; taps[0] is the newest sample.
module moving_avg_sched_lane (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            shift,
    input  logic [7:0]      din,
    output logic [3:0][7:0] taps
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        taps <= '0;
        else if (clr)   taps <= '0;
        else if (shift) taps <= {taps[2:0], din};
    end
endmodule

module moving_avg_sched (
    input  logic              system1000,
    input  logic              system1000_rst,
    input  logic [3:0]        req_i,
    input  logic [31:0]       data_i,
    input  logic              flush_i,
    output logic [3:0]        ack_o,
    output logic signed [7:0] avg_o,
    output logic [1:0]        chan_o,
    output logic              valid_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t              state, state_nx;
    logic [1:0]          cnt;
    logic signed [9:0]   sum, sum_nx;
    logic [1:0]          ptr;
    logic [1:0]          gsel;
    logic [1:0]          rr_sel;
    logic                rr_hit;
    logic                grant;
    logic                flush_clr;
    logic [3:0][3:0][7:0] hist;
    logic [7:0]          tap;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        logic [1:0] cand;
        rr_sel = ptr;
        rr_hit = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!rr_hit && req_i[cand]) begin
                rr_sel = cand;
                rr_hit = 1'b1;
            end
        end
    end

    // Next-state logic; flush and request are only looked at in IDLE.
    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        flush_clr = 1'b0;
        case (state)
            IDLE: begin
                if (flush_i) begin
                    flush_clr = 1'b1;
                end else if (rr_hit) begin
                    grant    = 1'b1;
                    state_nx = ACC;
                end
            end
            ACC:     if (cnt == 2'd3) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) state <= IDLE;
        else                state <= state_nx;
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            moving_avg_sched_lane u_lane (
                .clk   (system1000),
                .rst   (system1000_rst),
                .clr   (flush_clr),
                .shift (grant && (rr_sel == 2'(k))),
                .din   (data_i[8*k +: 8]),
                .taps  (hist[k])
            );
        end
    endgenerate

    assign tap    = hist[gsel][cnt];
    assign sum_nx = sum + {{2{tap[7]}}, tap};

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            cnt     <= '0;
            sum     <= '0;
            ptr     <= 2'd3;
            gsel    <= '0;
            ack_o   <= '0;
            avg_o   <= '0;
            chan_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            ack_o   <= '0;
            valid_o <= 1'b0;
            if (grant) begin
                ptr   <= rr_sel;
                gsel  <= rr_sel;
                ack_o <= 4'b0001 << rr_sel;
                sum   <= '0;
                cnt   <= '0;
            end
            if (state == ACC) begin
                sum <= sum_nx;
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    // Dropping the two LSBs of the signed sum floors toward -inf.
                    avg_o   <= sum_nx[9:2];
                    chan_o  <= gsel;
                    valid_o <= 1'b1;
                end
            end
        end
    end

    assign busy_o = (state != IDLE);
endmodule

// File: tb/tb_moving_avg_sched.sv
module tb_moving_avg_sched;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        req_i = '0;
    logic [31:0]       data_i = '0;
    logic              flush_i = 1'b0;
    logic [3:0]        ack;
    logic signed [7:0] avg;
    logic [1:0]        chan;
    logic              valid;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ack_cyc = 0;

    // Reference state: plain per-channel sample lists, newest first.
    int m_hist[4][4];
    int m_ptr;

    moving_avg_sched dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .req_i          (req_i),
        .data_i         (data_i),
        .flush_i        (flush_i),
        .ack_o          (ack),
        .avg_o          (avg),
        .chan_o         (chan),
        .valid_o        (valid),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++)
            for (int t = 0; t < 4; t++) m_hist[c][t] = 0;
        m_ptr = 3;
    endtask

    // Predicts the outcome of presenting req/data/flush in IDLE and commits it.
    task automatic model_step(input logic [3:0] req, input logic [31:0] data, input logic flush,
                              output int e_ack, output int e_valid, output int e_avg, output int e_chan);
        int g, s;
        logic [7:0] smp;
        e_ack = 0; e_valid = 0; e_avg = 0; e_chan = 0;
        if (flush) begin
            for (int c = 0; c < 4; c++)
                for (int t = 0; t < 4; t++) m_hist[c][t] = 0;
            return;
        end
        g = -1;
        for (int i = 1; i <= 4; i++)
            if (g < 0 && req[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
        if (g < 0) return;
        m_ptr = g;
        for (int t = 3; t > 0; t--) m_hist[g][t] = m_hist[g][t-1];
        smp = data[8*g +: 8];
        m_hist[g][0] = int'($signed(smp));
        s = 0;
        for (int t = 0; t < 4; t++) s += m_hist[g][t];
        e_ack   = 1 << g;
        e_valid = 1;
        e_avg   = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        e_chan  = g;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_ack", int'(ack), 0);
        chk("rst_avg", int'(avg), 0);
        chk("rst_chan", int'(chan), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // mode 0: drop inputs after grant; 1: hold req; 2: random noise on inputs.
    task automatic perturb(input int mode);
        if (mode == 0) begin
            req_i = '0; flush_i = 1'b0;
        end else if (mode == 2) begin
            req_i = 4'($urandom); flush_i = 1'($urandom); data_i = $urandom;
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge after E5.
    task automatic txn(input logic [3:0] req, input logic [31:0] data, input logic flush, input int mode,
                       output int o_ack, output int o_valid, output int o_avg, output int o_chan);
        req_i = req; data_i = data; flush_i = flush;
        @(negedge clk);
        o_ack = int'(ack); o_valid = 0; o_avg = int'(avg); o_chan = int'(chan);
        if (ack == 4'b0) begin
            chk("idle_busy", int'(busy), 0);
            chk("idle_valid", int'(valid), 0);
            req_i = '0; flush_i = 1'b0;
            return;
        end
        ack_cyc = cyc;
        chk("grant_busy", int'(busy), 1);
        perturb(mode);
        repeat (3) begin
            @(negedge clk);
            chk("acc_ack", int'(ack), 0);
            chk("acc_valid", int'(valid), 0);
            chk("acc_busy", int'(busy), 1);
            perturb(mode);
        end
        @(negedge clk);
        o_valid = int'(valid); o_avg = int'(avg); o_chan = int'(chan);
        chk("out_ack", int'(ack), 0);
        chk("out_busy", int'(busy), 1);
        perturb(mode);
        @(negedge clk);
        chk("post_valid", int'(valid), 0);
        chk("post_busy", int'(busy), 0);
        chk("post_ack", int'(ack), 0);
        chk("avg_hold", int'(avg), o_avg);
        req_i = '0; flush_i = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        flush;
        int          ack;
        int          valid;
        int          avg;
        int          chan;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int a, v, av, ch, ea, ev, eav, ech, prev;
        logic [3:0]  r;
        logic [31:0] d;
        logic        f;
        int          md;

        tbl[0] = '{4'b0001, 32'h0000_0028, 1'b0, 1, 1,   10, 0};
        tbl[1] = '{4'b0001, 32'h0000_0028, 1'b0, 1, 1,   20, 0};
        tbl[2] = '{4'b0100, 32'h00FF_0000, 1'b0, 4, 1,   -1, 2};
        tbl[3] = '{4'b0100, 32'h0080_0000, 1'b0, 4, 1,  -33, 2};
        tbl[4] = '{4'b0100, 32'h0080_0000, 1'b0, 4, 1,  -65, 2};
        tbl[5] = '{4'b0100, 32'h0080_0000, 1'b0, 4, 1,  -97, 2};
        tbl[6] = '{4'b0100, 32'h0080_0000, 1'b0, 4, 1, -128, 2};
        tbl[7] = '{4'b0010, 32'h0000_0800, 1'b1, 0, 0,    0, 0};
        tbl[8] = '{4'b0010, 32'h0000_0800, 1'b0, 2, 1,    2, 1};
        tbl[9] = '{4'b0001, 32'h0000_0004, 1'b0, 1, 1,    1, 0};

        // Directed table: single channel, negative floor, flush priority.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            txn(tbl[i].req, tbl[i].data, tbl[i].flush, 0, a, v, av, ch);
            chk($sformatf("tbl%0d_ack", i), a, tbl[i].ack);
            chk($sformatf("tbl%0d_valid", i), v, tbl[i].valid);
            if (tbl[i].valid != 0) begin
                chk($sformatf("tbl%0d_avg", i), av, tbl[i].avg);
                chk($sformatf("tbl%0d_chan", i), ch, tbl[i].chan);
            end
        end

        // Round robin with all requests held high.
        do_reset();
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            model_step(4'hF, d, 1'b0, ea, ev, eav, ech);
            txn(4'hF, d, 1'b0, 1, a, v, av, ch);
            chk($sformatf("rr%0d_ack", i), a, 1 << (i % 4));
            chk($sformatf("rr%0d_avg", i), av, eav);
            if (i > 0) chk($sformatf("rr%0d_interval", i), ack_cyc - prev, 6);
            prev = ack_cyc;
        end

        // Reset during ACC aborts the transaction.
        do_reset();
        txn(4'b0001, 32'h0000_0032, 1'b0, 0, a, v, av, ch);
        chk("pre_abort_avg", av, 12);
        req_i = 4'b0001; data_i = 32'h0000_0010;
        @(negedge clk);
        chk("abort_ack", int'(ack), 1);
        req_i = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ack0", int'(ack), 0);
        chk("abort_avg0", int'(avg), 0);
        chk("abort_chan0", int'(chan), 0);
        chk("abort_valid0", int'(valid), 0);
        chk("abort_busy0", int'(busy), 0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_valid", int'(valid), 0);
        end
        rst = 1'b0;
        model_reset();
        txn(4'b1000, 32'h1400_0000, 1'b0, 0, a, v, av, ch);
        chk("after_abort_ack", a, 8);
        chk("after_abort_avg", av, 5);
        chk("after_abort_chan", ch, 3);

        // Randomized traffic with input noise during ACC/OUT, against the model.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r  = 4'($urandom_range(0, 15));
            d  = $urandom;
            f  = ($urandom_range(0, 7) == 0);
            md = $urandom_range(0, 2);
            model_step(r, d, f, ea, ev, eav, ech);
            txn(r, d, f, md, a, v, av, ch);
            chk($sformatf("rnd%0d_ack", i), a, ea);
            chk($sformatf("rnd%0d_valid", i), v, ev);
            if (ev != 0) begin
                chk($sformatf("rnd%0d_avg", i), av, eav);
                chk($sformatf("rnd%0d_chan", i), ch, ech);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/moving_avg_sched.md
MOVING_AVG_SCHED -- requirements
Module: moving_avg_sched

Interface
REQ-001: The block SHALL have the port system1000, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002: The block SHALL have the port system1000_rst, input, 1 bit: asynchronous, active-high reset.
REQ-003: The block SHALL have the port req_i, input, 4 bits: per-channel sample request; bit k belongs to channel k.
REQ-004: The block SHALL have the port data_i, input, 32 bits: four signed 8-bit samples; channel k occupies bits [8k+7:8k].
REQ-005: The block SHALL have the port flush_i, input, 1 bit: clears all channel histories; sampled only in IDLE.
REQ-006: The block SHALL have the port ack_o, output, 4 bits: one-hot grant acknowledge, registered.
REQ-007: The block SHALL have the port avg_o, output, 8 bits signed: moving-average result, registered.
REQ-008: The block SHALL have the port chan_o, output, 2 bits: channel index of avg_o, registered.
REQ-009: The block SHALL have the port valid_o, output, 1 bit: avg_o/chan_o qualifier, one-cycle pulse.
REQ-010: The block SHALL have the port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011: The block SHALL time-share one accumulator among 4 channels, each holding a private 4-deep history of signed 8-bit samples (newest at tap 0).
REQ-012: The FSM SHALL have the states IDLE, ACC and OUT.
REQ-013: In IDLE with flush_i=1 at edge E, all 16 history entries SHALL become 0, no grant SHALL occur and the FSM SHALL stay in IDLE; flush_i SHALL take priority over req_i.
REQ-014: In IDLE with flush_i=0 and req_i!=0 at edge E0, the block SHALL grant one channel g by round-robin, searching ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the last granted channel.
REQ-015: At E0 the block SHALL set ptr=g, shift history[g] (tap3 dropped, tap0=data_i[g]), set ack_o=one-hot(g) for exactly the cycle E0..E1, clear the sum and enter ACC with cnt=0.
REQ-016: In ACC, edges E1..E4 SHALL each add the sign-extended history[g][cnt] into a 10-bit signed sum and increment cnt; at E4 the FSM SHALL enter OUT.
REQ-017: At E4 the block SHALL register avg_o = (full 4-tap sum) arithmetic-shifted right by 2 (floor toward minus infinity, always fits 8 bits) and chan_o=g.
REQ-018: valid_o SHALL be high only while in OUT (cycle E4..E5); at E5 the FSM SHALL return to IDLE.
REQ-019: The earliest next grant SHALL be at E6, giving an issue interval of 6 cycles per sample.
REQ-020: req_i SHALL be ignored outside IDLE; a request still high in IDLE after its ack SHALL be treated as a new sample.
REQ-021: flush_i outside IDLE SHALL be ignored (not queued).
REQ-022: avg_o and chan_o SHALL hold their last values when valid_o=0; ack_o SHALL be 0 except in the cycle of REQ-015.
REQ-023: busy_o SHALL be 1 in ACC and OUT and 0 in IDLE.

Reset
REQ-024: While system1000_rst=1, the block SHALL immediately (asynchronously) force state=IDLE, cnt=0, sum=0, all histories=0, ptr=3 (channel 0 first), ack_o=0, avg_o=0, chan_o=0, valid_o=0 and busy_o=0.
REQ-025: Reset asserted mid-transaction SHALL abort it with no valid_o pulse; after release, the first grant SHALL follow REQ-014 from ptr=3.

Verification
REQ-026: The bench SHALL cover a single channel: after reset, req_i=0001 with sample 40 -> ack_o=0001 one cycle, valid_o 4 cycles later with avg_o=10 and chan_o=0; a second sample of 40 -> avg_o=20.
REQ-027: The bench SHALL cover negative rounding: after reset, channel 2 with sample -1 -> avg_o=-1; channel 2 with samples -128 x4 -> avg_o=-128.
REQ-028: The bench SHALL cover round-robin: req_i=1111 held constantly -> grant order 0,1,2,3,0, with grants 6 cycles apart and busy_o low exactly 1 cycle between transactions.
REQ-029: The bench SHALL cover flush priority: in IDLE, flush_i=1 with req_i=0010 -> no ack; the next request on channel 1 with sample 8 -> avg_o=2, with no prior history contributing.
REQ-030: The bench SHALL cover reset mid-operation: assert reset during ACC -> outputs 0 immediately, no valid_o pulse; after release, req_i=1000 -> grant channel 3 with avg computed from zero history.
REQ-031: The bench SHALL cover ignored inputs: toggle req_i and flush_i during ACC/OUT -> no ack_o, and history unchanged, with the next result matching the reference model.
